// File: rtl/microwave_cook_ctrl.sv
// microwave_cook_ctrl: IDLE/COOK/PAUSE/DONE sequencer driving the down counter, magnetron, lamp and beeper.
module microwave_cook_ctrl #(
    parameter int BEEP_COUNT = 3,
    parameter int MAX_SECONDS = 59
) (
    input  logic       clk_1Hz,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       stop_btn,
    input  logic       door_open,
    input  logic [5:0] load_minutes,
    input  logic [5:0] load_seconds,
    input  logic       timer_end,
    output logic       count_en,
    output logic       counter_load,
    output logic       magnetron_on,
    output logic       lamp_on,
    output logic       beep,
    output logic [1:0] state,
    output logic       load_error
);
    typedef enum logic [1:0] {IDLE, COOK, PAUSE, DONE} state_t;

    localparam logic [3:0] LAST_BEEP = 4'(2 * BEEP_COUNT - 1);

    state_t     state_q, state_d;
    logic [3:0] beep_cnt, cnt_d;
    logic       start_q, stop_q, err_d;
    logic       start_rise, stop_rise, valid;

    assign start_rise = start_btn & ~start_q;
    assign stop_rise  = stop_btn & ~stop_q;
    assign valid      = (load_minutes != 6'd0 || load_seconds != 6'd0) && load_seconds <= 6'(MAX_SECONDS);
    assign state      = state_q;

    always_comb begin
        state_d = state_q;
        err_d = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = (start_rise && !door_open && valid) ? COOK : IDLE;
                err_d = start_rise && (door_open || !valid);
            end
            COOK: state_d = timer_end ? DONE : (door_open || stop_rise) ? PAUSE : COOK;
            PAUSE: state_d = stop_rise ? IDLE : (start_rise && !door_open) ? COOK : PAUSE;
            DONE: state_d = (stop_rise || door_open || beep_cnt == LAST_BEEP) ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        cnt_d = (state_d == DONE && state_q == DONE) ? beep_cnt + 4'd1 : 4'd0;
    end

    // Outputs are decoded from the next state so they move together with state.
    always_ff @(posedge clk_1Hz) begin
        if (rst) begin
            state_q <= IDLE;
            beep_cnt <= 4'd0;
            start_q <= 1'b0;
            stop_q <= 1'b0;
            count_en <= 1'b0;
            counter_load <= 1'b1;
            magnetron_on <= 1'b0;
            lamp_on <= 1'b0;
            beep <= 1'b0;
            load_error <= 1'b0;
        end else begin
            state_q <= state_d;
            beep_cnt <= cnt_d;
            start_q <= start_btn;
            stop_q <= stop_btn;
            count_en <= state_d == COOK;
            counter_load <= state_d == IDLE;
            magnetron_on <= state_d == COOK;
            lamp_on <= (state_d == IDLE) ? door_open : 1'b1;
            beep <= state_d == DONE && !cnt_d[0];
            load_error <= err_d;
        end
    end
endmodule

// File: tb/tb_microwave_cook_ctrl.sv
// tb_microwave_cook_ctrl: directed scenarios plus randomized traffic checked against a behavioural model.
module tb_microwave_cook_ctrl;
    logic clk_1Hz = 1'b0, rst = 1'b1, start_btn = 1'b0, stop_btn = 1'b0, door_open = 1'b0, timer_end = 1'b0;
    logic [5:0] load_minutes = 6'd0, load_seconds = 6'd0;
    logic count_en, counter_load, magnetron_on, lamp_on, beep, load_error;
    logic [1:0] state;
    int n_checks = 0, n_fail = 0;

    always #5 clk_1Hz = ~clk_1Hz;

    microwave_cook_ctrl dut (
        .clk_1Hz(clk_1Hz), .rst(rst), .start_btn(start_btn), .stop_btn(stop_btn),
        .door_open(door_open), .load_minutes(load_minutes), .load_seconds(load_seconds),
        .timer_end(timer_end), .count_en(count_en), .counter_load(counter_load),
        .magnetron_on(magnetron_on), .lamp_on(lamp_on), .beep(beep), .state(state),
        .load_error(load_error)
    );

    // Model: mode 0..3, ticks spent in DONE, previous button levels.
    int m_mode = 0, m_elapsed = 0;
    bit m_start_prev = 0, m_stop_prev = 0, m_err = 0, m_lamp = 0;

    task automatic model_step();
        bit sr, pr, ok;
        sr = start_btn && !m_start_prev;
        pr = stop_btn && !m_stop_prev;
        ok = (load_minutes != 0 || load_seconds != 0) && load_seconds <= 59;
        m_err = 0;
        if (rst) begin
            m_mode = 0; m_elapsed = 0; m_start_prev = 0; m_stop_prev = 0; m_lamp = 0;
        end else begin
            case (m_mode)
                0: if (sr) begin if (!door_open && ok) m_mode = 1; else m_err = 1; end
                1: if (timer_end) begin m_mode = 3; m_elapsed = 0; end
                   else if (door_open || pr) m_mode = 2;
                2: if (pr) m_mode = 0; else if (sr && !door_open) m_mode = 1;
                default: if (pr || door_open) m_mode = 0;
                         else begin m_elapsed++; if (m_elapsed == 2 * 3) m_mode = 0; end
            endcase
            m_lamp = (m_mode == 0) ? door_open : 1'b1;
            m_start_prev = start_btn;
            m_stop_prev = stop_btn;
        end
    endtask

    function automatic logic [7:0] model_vec();
        return {2'(m_mode), m_mode == 1, m_mode == 0, m_mode == 1, m_lamp,
                m_mode == 3 && (m_elapsed % 2 == 0), m_err};
    endfunction

    function automatic logic [7:0] obs();
        return {state, count_en, counter_load, magnetron_on, lamp_on, beep, load_error};
    endfunction

    task automatic tick();
        @(posedge clk_1Hz);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1; tick();
        n_checks++;
        if (obs() !== 8'b00_010000) begin n_fail++; $display("FAIL reset got=%b exp=%b", obs(), 8'b00_010000); end
        rst = 0;
    endtask

    task automatic test_cook_done();
        logic [7:0] e;
        load_minutes = 0; load_seconds = 3; door_open = 0; start_btn = 1; tick();
        n_checks++;
        if (obs() !== 8'b01_101100) begin n_fail++; $display("FAIL start_cook got=%b exp=%b", obs(), 8'b01_101100); end
        start_btn = 0; tick(); tick();
        timer_end = 1; tick(); timer_end = 0;
        n_checks++;
        if (obs() !== 8'b11_000110) begin n_fail++; $display("FAIL done_entry got=%b exp=%b", obs(), 8'b11_000110); end
        for (int i = 1; i < 6; i++) begin
            tick();
            e = (i % 2) ? 8'b11_000100 : 8'b11_000110;
            n_checks++;
            if (obs() !== e) begin n_fail++; $display("FAIL beep_seq[%0d] got=%b exp=%b", i, obs(), e); end
        end
        tick();
        n_checks++;
        if (obs() !== 8'b00_010000) begin n_fail++; $display("FAIL done_to_idle got=%b exp=%b", obs(), 8'b00_010000); end
    endtask

    task automatic test_pause();
        load_minutes = 1; load_seconds = 0; start_btn = 1; tick(); start_btn = 0;
        door_open = 1; tick();
        n_checks++;
        if (obs() !== 8'b10_000100) begin n_fail++; $display("FAIL door_pause got=%b exp=%b", obs(), 8'b10_000100); end
        door_open = 0; tick();
        start_btn = 1; tick(); start_btn = 0;
        n_checks++;
        if (obs() !== 8'b01_101100) begin n_fail++; $display("FAIL resume got=%b exp=%b", obs(), 8'b01_101100); end
        stop_btn = 1; tick(); stop_btn = 0;
        n_checks++;
        if (obs() !== 8'b10_000100) begin n_fail++; $display("FAIL stop_pause got=%b exp=%b", obs(), 8'b10_000100); end
        tick();
        stop_btn = 1; tick(); stop_btn = 0;
        n_checks++;
        if (obs() !== 8'b00_010000) begin n_fail++; $display("FAIL stop_clear got=%b exp=%b", obs(), 8'b00_010000); end
        tick();
    endtask

    task automatic test_load_error();
        logic [5:0] mins [3] = '{6'd0, 6'd0, 6'd0};
        logic [5:0] secs [3] = '{6'd60, 6'd0, 6'd5};
        logic       doors [3] = '{1'b0, 1'b0, 1'b1};
        logic [7:0] e;
        for (int i = 0; i < 3; i++) begin
            load_minutes = mins[i]; load_seconds = secs[i]; door_open = doors[i];
            start_btn = 1; tick();
            e = doors[i] ? 8'b00_010101 : 8'b00_010001;
            n_checks++;
            if (obs() !== e) begin n_fail++; $display("FAIL load_err[%0d] got=%b exp=%b", i, obs(), e); end
            tick(); start_btn = 0;
            e = doors[i] ? 8'b00_010100 : 8'b00_010000;
            n_checks++;
            if (obs() !== e) begin n_fail++; $display("FAIL load_err_width[%0d] got=%b exp=%b", i, obs(), e); end
            door_open = 0; tick();
        end
    endtask

    task automatic test_priority();
        load_minutes = 0; load_seconds = 10; start_btn = 1; tick(); start_btn = 0; tick();
        timer_end = 1; door_open = 1; stop_btn = 1; tick();
        n_checks++;
        if (obs() !== 8'b11_000110) begin n_fail++; $display("FAIL done_wins got=%b exp=%b", obs(), 8'b11_000110); end
        timer_end = 0; stop_btn = 0; tick();
        n_checks++;
        if (obs() !== 8'b00_010100) begin n_fail++; $display("FAIL done_door_held got=%b exp=%b", obs(), 8'b00_010100); end
        door_open = 0; tick();
    endtask

    task automatic test_done_door();
        load_minutes = 0; load_seconds = 5; start_btn = 1; tick(); start_btn = 0;
        timer_end = 1; tick(); timer_end = 0;
        tick();
        door_open = 1; tick();
        n_checks++;
        if (obs() !== 8'b00_010100) begin n_fail++; $display("FAIL done_door_abort got=%b exp=%b", obs(), 8'b00_010100); end
        door_open = 0; tick();
    endtask

    task automatic test_hold_start_reset();
        int transitions = 0;
        logic [1:0] prev;
        load_minutes = 0; load_seconds = 30; start_btn = 1;
        for (int i = 0; i < 5; i++) begin
            prev = state; tick();
            if (prev == 2'd0 && state == 2'd1) transitions++;
        end
        n_checks++;
        if (transitions != 1 || state !== 2'd1) begin
            n_fail++; $display("FAIL hold_start transitions=%0d state=%0d exp=1,1", transitions, state);
        end
        start_btn = 0; tick();
        rst = 1; tick();
        n_checks++;
        if (obs() !== 8'b00_010000) begin n_fail++; $display("FAIL reset_in_cook got=%b exp=%b", obs(), 8'b00_010000); end
        rst = 0; tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom % 64) == 0;
            start_btn = ($urandom % 4) == 0;
            stop_btn = ($urandom % 10) == 0;
            door_open = ($urandom % 8) == 0;
            timer_end = ($urandom % 6) == 0;
            load_minutes = 6'($urandom % 3);
            load_seconds = (($urandom % 4) == 0) ? 6'($urandom_range(55, 63)) : 6'($urandom % 4);
            tick();
            n_checks++;
            if (obs() !== model_vec()) begin
                n_fail++; $display("FAIL random[%0d] got=%b exp=%b", i, obs(), model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_cook_done();
        test_pause();
        test_load_error();
        test_priority();
        test_done_door();
        test_hold_start_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
